// File: rtl/grover_measure.sv
// Grover readout: latches the final amplitude vector, squares one sample per cycle
// and reports the most probable basis index, its probability and the total probability.
module grover_measure #(
    parameter int num_bit        = 3,
    parameter int fixedpoint_bit = 24,
    parameter int num_sample     = 2**num_bit
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic signed [fixedpoint_bit-1:0]      amp_in [0:num_sample-1],
    output logic                                  busy,
    output logic                                  done,
    output logic [num_bit-1:0]                    measured_index,
    output logic [fixedpoint_bit-1:0]             max_prob,
    output logic [fixedpoint_bit+num_bit-1:0]     prob_sum
);

    localparam int fw = fixedpoint_bit;
    localparam int sw = fixedpoint_bit + num_bit;
    localparam int pw = 2 * fixedpoint_bit;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [fw-1:0] amp_reg [0:num_sample-1];
    logic [num_bit-1:0]   cnt_reg;
    logic [num_bit-1:0]   max_idx_reg;
    logic [fw-1:0]        max_reg;
    logic [sw-1:0]        sum_reg;

    logic [num_bit-1:0]   index_out_reg;
    logic [fw-1:0]        max_out_reg;
    logic [sw-1:0]        sum_out_reg;

    logic                 accept;
    logic                 last_sample;
    logic signed [fw-1:0] amp_cur;
    logic signed [pw-1:0] sq;
    logic [pw-1:0]        sq_shift;
    logic                 sat;
    logic [fw-1:0]        p;
    logic                 take_new_max;
    logic [sw-1:0]        sum_next;
    logic [fw-1:0]        max_next;
    logic [num_bit-1:0]   max_idx_next;

    assign accept      = (state_reg == IDLE) && start;
    assign last_sample = (cnt_reg == num_bit'(num_sample - 1));

    // Squaring datapath: Q1.f * Q1.f gives Q2.2f; dropping f low bits returns to f fraction bits.
    // Only -2.0 squared reaches 4.0, which no longer fits and saturates.
    assign amp_cur  = amp_reg[cnt_reg];
    assign sq       = amp_cur * amp_cur;
    assign sq_shift = $unsigned(sq) >> (fw - 2);
    assign sat      = |sq_shift[pw-1:fw];
    assign p        = sat ? '1 : sq_shift[fw-1:0];

    // Strict compare keeps the lowest index on ties.
    assign take_new_max = (p > max_reg);
    assign sum_next     = sum_reg + sw'(p);
    assign max_next     = take_new_max ? p : max_reg;
    assign max_idx_next = take_new_max ? cnt_reg : max_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (last_sample) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_sample; i++) begin
                amp_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < num_sample; i++) begin
                amp_reg[i] <= amp_in[i];
            end
        end
    end

    // Running accumulators; the result registers load on the final sample so they
    // are already valid during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            max_idx_reg   <= '0;
            max_reg       <= '0;
            sum_reg       <= '0;
            index_out_reg <= '0;
            max_out_reg   <= '0;
            sum_out_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg     <= '0;
                        max_idx_reg <= '0;
                        max_reg     <= '0;
                        sum_reg     <= '0;
                    end
                end
                SCAN: begin
                    cnt_reg     <= cnt_reg + num_bit'(1);
                    sum_reg     <= sum_next;
                    max_reg     <= max_next;
                    max_idx_reg <= max_idx_next;
                    if (last_sample) begin
                        index_out_reg <= max_idx_next;
                        max_out_reg   <= max_next;
                        sum_out_reg   <= sum_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE);
    assign measured_index = index_out_reg;
    assign max_prob       = max_out_reg;
    assign prob_sum       = sum_out_reg;

endmodule

// File: tb/tb_grover_measure.sv
// Randomized and directed check of grover_measure against an arithmetic model of
// probability = amplitude^2, argmax (lowest index on ties) and total sum.
module tb_grover_measure;

    localparam int NB = 3;
    localparam int FW = 24;
    localparam int NS = 8;
    localparam int SW = FW + NB;
    localparam longint PMAX = (64'd1 << FW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [FW-1:0] amp_in [0:NS-1];
    logic                 busy;
    logic                 done;
    logic [NB-1:0]        measured_index;
    logic [FW-1:0]        max_prob;
    logic [SW-1:0]        prob_sum;

    int     n_checks = 0;
    int     n_errors = 0;
    longint vec [NS];
    longint prev_idx = 0, prev_max = 0, prev_sum = 0;

    grover_measure #(
        .num_bit(NB),
        .fixedpoint_bit(FW),
        .num_sample(NS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .amp_in(amp_in),
        .busy(busy),
        .done(done),
        .measured_index(measured_index),
        .max_prob(max_prob),
        .prob_sum(prob_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: amplitudes as real-valued integers scaled by 2^22; probability is the
    // floored square scaled back to 2^22, clamped to the output range.
    task automatic model(output longint idx, output longint mx, output longint sm);
        longint a, sq, p;
        idx = 0;
        mx  = 0;
        sm  = 0;
        for (int i = 0; i < NS; i++) begin
            a  = vec[i];
            sq = a * a;
            p  = sq / (64'd1 << (FW - 2));
            if (p > PMAX) p = PMAX;
            sm += p;
            if (p > mx) begin
                mx  = p;
                idx = i;
            end
        end
    endtask

    task automatic apply_vec();
        for (int i = 0; i < NS; i++) begin
            amp_in[i] = vec[i][FW-1:0];
        end
    endtask

    task automatic scramble_amp();
        for (int i = 0; i < NS; i++) begin
            amp_in[i] = FW'($urandom);
        end
    endtask

    task automatic set_all(input longint v);
        for (int i = 0; i < NS; i++) vec[i] = v;
    endtask

    // One measurement, started at a negedge; cycle k is sampled at the negedge after the k-th posedge.
    task automatic run(input string name, input bit busy_poke);
        longint e_idx, e_max, e_sum;
        int done_at, dones, busy_cycles;
        model(e_idx, e_max, e_sum);
        apply_vec();
        start = 1'b1;
        done_at = -1;
        dones = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                scramble_amp();
                check({name, " hold_idx"}, 64'(measured_index), prev_idx);
                check({name, " hold_sum"}, 64'(prob_sum), prev_sum);
            end
            if (busy_poke && k == 4) start = 1'b1;
            if (busy_poke && k == 5) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (k == 9) begin
                check({name, " index"}, 64'(measured_index), e_idx);
                check({name, " max_prob"}, 64'(max_prob), e_max);
                check({name, " prob_sum"}, 64'(prob_sum), e_sum);
            end
        end
        check({name, " done_cycle"}, 64'(done_at), 64'(9));
        check({name, " done_count"}, 64'(dones), 64'(1));
        check({name, " busy_cycles"}, 64'(busy_cycles), 64'(9));
        check({name, " held_max"}, 64'(max_prob), e_max);
        $display("run %s: index=%0d max_prob=0x%06h prob_sum=0x%07h done_cycle=%0d",
                 name, measured_index, max_prob, prob_sum, done_at);
        prev_idx = e_idx;
        prev_max = e_max;
        prev_sum = e_sum;
    endtask

    task automatic random_vec();
        logic signed [FW-1:0] t;
        int r;
        for (int i = 0; i < NS; i++) begin
            r = $urandom_range(0, 15);
            t = FW'($urandom);
            if (r == 0) begin
                vec[i] = -(64'sd1 <<< (FW - 1));
            end else if (r == 1 && i > 0 && vec[i-1] != -(64'sd1 <<< (FW - 1))) begin
                vec[i] = -vec[i-1];
            end else if (r < 5) begin
                vec[i] = longint'($urandom_range(0, 4095)) - 2048;
            end else begin
                vec[i] = t;
            end
        end
    endtask

    initial begin
        int dones;
        set_all(0);
        apply_vec();
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset index", 64'(measured_index), 64'(0));
        check("reset max_prob", 64'(max_prob), 64'(0));
        check("reset prob_sum", 64'(prob_sum), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        set_all(0);
        run("all_zero", 1'b0);

        set_all(64'h100000);
        vec[5] = 64'h200000;
        run("peak5", 1'b0);

        vec[6] = -64'sh300000;
        run("neg6", 1'b0);

        set_all(64'h200000);
        run("tie_all", 1'b0);

        set_all(0);
        vec[3] = -64'sh800000;
        run("sat3", 1'b0);

        // Abort mid-scan: outputs must drop to zero at once and no done may follow.
        set_all(64'h180000);
        apply_vec();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort index", 64'(measured_index), 64'(0));
        check("abort max_prob", 64'(max_prob), 64'(0));
        check("abort prob_sum", 64'(prob_sum), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", 64'(dones), 64'(0));
        prev_idx = 0;
        prev_max = 0;
        prev_sum = 0;

        set_all(64'h080000);
        vec[2] = -64'sh3FFFFF;
        run("busy_poke", 1'b1);

        for (int n = 0; n < 20; n++) begin
            random_vec();
            run($sformatf("rand%0d", n), (n % 4) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
